// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch front end: default bus widths,
// the fetch FSM state encoding and the sequential PC increment.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_DATA_WIDTH = 32;
    localparam int PC_STEP         = 4;

    // Fetch FSM states:
    //   FETCH_IDLE    - no request outstanding, may issue one
    //   FETCH_WAIT    - request outstanding, response will be kept
    //   FETCH_DISCARD - request outstanding, response will be dropped
    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO holding {pc, instruction} entries.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push      - write din (accepted when not full, or when full with a pop)
//   pop       - remove the head (ignored when empty)
//   flush     - drop all entries; overrides push and pop
//   din/dout  - write data / registered head entry
//   full, empty, count - occupancy status (count is log2(DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is only legal because a pop frees the slot
    // in the same cycle; an empty FIFO cannot pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch front end: owns the PC, issues one ROM request at a time,
// buffers responses tagged with their PC in a prefetch FIFO and presents the
// head to decode. A branch flushes the FIFO, redirects the PC and drops any
// in-flight response.
//
// Handshakes:
//   ROM side   : rom_enable is a one-cycle request pulse with rom_addr_out;
//                the address stays stable until rom_ready_in (one-cycle pulse,
//                at least one cycle later) returns rom_data_in. At most one
//                request is outstanding.
//   Decode side: the head transfers on a cycle where inst_valid_out and
//                inst_ready_in are both high; the head stays stable otherwise.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   rom_addr_out, rom_enable      - fetch request
//   rom_ready_in, rom_data_in     - fetch response
//   branch_en_in, branch_addr_in  - redirect pulse and target
//   inst_valid_out, inst_out, inst_pc_out, inst_ready_in - decode interface
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = inst_fetch_pkg::INST_ADDR_WIDTH,
    parameter int INST_DATA_WIDTH = inst_fetch_pkg::INST_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [INST_ADDR_WIDTH-1:0] rom_addr_out,
    output logic                       rom_enable,
    input  logic                       rom_ready_in,
    input  logic [INST_DATA_WIDTH-1:0] rom_data_in,
    input  logic                       branch_en_in,
    input  logic [INST_ADDR_WIDTH-1:0] branch_addr_in,
    output logic                       inst_valid_out,
    output logic [INST_DATA_WIDTH-1:0] inst_out,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc_out,
    input  logic                       inst_ready_in
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = INST_ADDR_WIDTH + INST_DATA_WIDTH;

    fetch_state_t               state;
    fetch_state_t               state_next;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_ADDR_WIDTH-1:0] pc_next;
    logic [INST_ADDR_WIDTH-1:0] branch_target;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [PTR_W:0]             fifo_count;
    logic [ENTRY_W-1:0]         fifo_head;

    // Instructions are word aligned; the low two target bits are ignored.
    assign branch_target = branch_addr_in & ~INST_ADDR_WIDTH'(3);

    assign rom_addr_out   = pc;
    assign inst_valid_out = (fifo_count != '0);
    assign pop            = ~fifo_empty & inst_ready_in;
    assign {inst_pc_out, inst_out} = fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        rom_enable = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (branch_en_in) begin
                    pc_next = branch_target;
                end else if (!fifo_full && !rst) begin
                    // Only issue when a slot is free so the response always fits.
                    rom_enable = 1'b1;
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (branch_en_in) begin
                    pc_next = branch_target;
                    // A response arriving with the branch completes the request.
                    state_next = rom_ready_in ? FETCH_IDLE : FETCH_DISCARD;
                end else if (rom_ready_in) begin
                    push       = 1'b1;
                    pc_next    = pc + INST_ADDR_WIDTH'(PC_STEP);
                    state_next = FETCH_IDLE;
                end
            end
            FETCH_DISCARD: begin
                if (branch_en_in) begin
                    pc_next = branch_target;
                end
                // The stale response retires the request even if another
                // branch arrives with it; staying here would wait forever.
                if (rom_ready_in) begin
                    state_next = FETCH_IDLE;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_en_in),
        .din   ({pc, rom_data_in}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Bench for inst_fetch: a ROM responder with programmable latency, a
// reference model of the fetch stream kept as a queue of expected
// {pc, instruction} entries, a monitor comparing every cycle, directed
// scenarios followed by randomized traffic, and a final report.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr_out;
    logic          rom_enable;
    logic          rom_ready_in;
    logic [DW-1:0] rom_data_in;
    logic          branch_en_in;
    logic [AW-1:0] branch_addr_in;
    logic          inst_valid_out;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] inst_pc_out;
    logic          inst_ready_in;

    inst_fetch #(
        .INST_ADDR_WIDTH (AW),
        .INST_DATA_WIDTH (DW),
        .FIFO_DEPTH      (DEPTH),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr_out   (rom_addr_out),
        .rom_enable     (rom_enable),
        .rom_ready_in   (rom_ready_in),
        .rom_data_in    (rom_data_in),
        .branch_en_in   (branch_en_in),
        .branch_addr_in (branch_addr_in),
        .inst_valid_out (inst_valid_out),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_ready_in  (inst_ready_in)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    bit          outstanding;
    bit          drop_next;
    int          rom_lat = 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ROM responder ----------------
    bit          rom_pending = 0;
    int          rom_cd      = 0;
    logic [31:0] rom_pa      = '0;

    initial begin
        rom_ready_in = 1'b0;
        rom_data_in  = '0;
        forever begin
            @(negedge clk);
            if (rom_enable === 1'b1) begin
                rom_pending = 1;
                rom_cd      = rom_lat;
                rom_pa      = rom_addr_out;
            end
            @(posedge clk);
            #1;
            rom_ready_in = 1'b0;
            rom_data_in  = $urandom;
            if (rom_pending) begin
                rom_cd--;
                if (rom_cd == 0) begin
                    rom_ready_in = 1'b1;
                    rom_data_in  = rom_word(rom_pa);
                    rom_pending  = 0;
                end
            end
        end
    end

    // ---------------- monitor / reference model ----------------
    // Sampled mid-cycle: compares what the DUT shows now, then advances the
    // model to what the next rising edge should produce.
    int sz;
    bit exp_en;
    bit resp;

    initial begin
        model_pc    = RESET_PC;
        outstanding = 0;
        drop_next   = 0;
        forever begin
            @(negedge clk);
            sz     = exp_q.size();
            exp_en = !rst && !outstanding && (sz < DEPTH) && !branch_en_in;
            check("inst_valid", 64'(inst_valid_out), 64'(sz != 0));
            if (sz != 0) check("head", {inst_pc_out, inst_out}, exp_q[0]);
            check("rom_enable", 64'(rom_enable), 64'(exp_en));
            if (exp_en) check("rom_addr", 64'(rom_addr_out), 64'(model_pc));

            if (rst) begin
                exp_q.delete();
                model_pc    = RESET_PC;
                outstanding = 0;
                drop_next   = 0;
            end else begin
                resp = outstanding && rom_ready_in;
                if (sz != 0 && inst_ready_in && !branch_en_in) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
                if (resp) begin
                    outstanding = 0;
                    if (!branch_en_in && !drop_next) begin
                        exp_q.push_back({model_pc, rom_word(model_pc)});
                        model_pc = model_pc + 32'd4;
                    end
                    drop_next = 0;
                end
                if (exp_en) outstanding = 1;
                if (branch_en_in) begin
                    exp_q.delete();
                    model_pc = {branch_addr_in[31:2], 2'b00};
                    if (outstanding) drop_next = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_enable();
        int k;
        k = 0;
        while (rom_enable !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("wait_enable_timeout", 64'(rom_enable), 64'd1);
    endtask

    task automatic wait_rom_ready();
        int k;
        k = 0;
        while (rom_ready_in !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("wait_ready_timeout", 64'(rom_ready_in), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 64'(inst_valid_out), 64'd0);
        check("rst_inst", 64'(inst_out), 64'd0);
        check("rst_pc", 64'(inst_pc_out), 64'd0);
        check("rst_enable", 64'(rom_enable), 64'd0);
        check("rst_addr", 64'(rom_addr_out), 64'(RESET_PC));
    endtask

    task automatic pulse_branch(input logic [31:0] target);
        branch_en_in   = 1'b1;
        branch_addr_in = target;
        tick();
        branch_en_in   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        branch_en_in   = 1'b0;
        branch_addr_in = '0;
        inst_ready_in  = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;

        // Zero-wait ROM, consumer always ready: 0x0, 0x4, 0x8 ... every 2 cycles.
        repeat (12) tick();

        // Consumer stalled: FIFO fills with 0x0..0xC, one pop releases 0x10.
        rst           = 1'b1;
        inst_ready_in = 1'b0;
        tick();
        rst = 1'b0;
        repeat (14) tick();
        inst_ready_in = 1'b1;
        tick();
        inst_ready_in = 1'b0;
        repeat (6) tick();
        inst_ready_in = 1'b1;
        repeat (10) tick();

        // Branch to 0x103 one cycle into a 3-cycle fetch: response dropped.
        rom_lat = 3;
        wait_enable();
        tick();
        pulse_branch(32'h0000_0103);
        repeat (12) tick();

        // Branch coincident with the ROM response.
        rom_lat = 2;
        wait_rom_ready();
        pulse_branch(32'h0000_0200);
        repeat (8) tick();

        // PC wrap past 0xFFFFFFFC.
        rom_lat = 1;
        pulse_branch(32'hFFFF_FFF8);
        repeat (10) tick();

        // Reset during WAIT with the stale response arriving right after.
        rom_lat = 2;
        wait_enable();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        check("stale_ready_present", 64'(rom_ready_in), 64'd1);
        rst = 1'b0;
        repeat (8) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rom_lat        = $urandom_range(1, 3);
            inst_ready_in  = ($urandom_range(0, 3) != 0);
            branch_en_in   = ($urandom_range(0, 19) == 0);
            branch_addr_in = $urandom;
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst           = 1'b0;
        branch_en_in  = 1'b0;
        inst_ready_in = 1'b1;
        repeat (10) tick();

        check("pops_seen", 64'(n_pops > 50), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
